// File: rtl/ifid_queue.sv
// ifid_queue: IF->ID decoupling queue.
//   A DEPTH-entry circular buffer of {pc,inst} pairs between the fetch unit (producer) and the
//   decode/issue stage (consumer), with valid/ready handshakes on both sides and a synchronous
//   flush for discarding wrong-path instructions after a redirect.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_if_valid    fetch presents {i_if_pc, i_if_inst}
//   o_if_ready    queue can accept a push (not full)
//   o_id_valid    head entry valid (not empty)
//   o_id_pc/inst  head entry, show-ahead; RESET_PC/NOP_INST when empty
//   i_id_ready    ID consumes the head this cycle
//   i_flush       drop every entry, including a same-cycle push
//   o_count       occupancy, 0..DEPTH
module ifid_queue #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          DEPTH    = 2,
  parameter logic [INST_W-1:0]    NOP_INST = 32'h0000_0013,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_if_valid,
  input  logic [ADDR_W-1:0]          i_if_pc,
  input  logic [INST_W-1:0]          i_if_inst,
  output logic                       o_if_ready,
  output logic                       o_id_valid,
  output logic [ADDR_W-1:0]          o_id_pc,
  output logic [INST_W-1:0]          o_id_inst,
  input  logic                       i_id_ready,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CountFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CountOne  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  // Storage is not reset; contents are only ever observed through count_q.
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full, empty;
  logic push, pop;

  // Handshake status comes from registered state only, so o_if_ready has no path from
  // i_id_ready and a full queue refuses a push even when ID pops in the same cycle.
  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  assign push = i_if_valid & ~full;
  assign pop  = ~empty & i_id_ready;

  // Storage write; a flushed push never lands.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push && !i_flush) begin
      pc_mem_d[wr_ptr_q]   = i_if_pc;
      inst_mem_d[wr_ptr_q] = i_if_inst;
    end
  end

  // Pointer and occupancy update. Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      // Resynchronise the read side to the write side; push/pop this cycle are discarded.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_d = count_q + CountOne;
      end else if (pop && !push) begin
        count_d = count_q - CountOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  // Show-ahead head; forced to a harmless NOP at RESET_PC while empty.
  always_comb begin
    o_id_pc   = RESET_PC;
    o_id_inst = NOP_INST;
    if (!empty) begin
      o_id_pc   = pc_mem_q[rd_ptr_q];
      o_id_inst = inst_mem_q[rd_ptr_q];
    end
  end

  assign o_if_ready = ~full;
  assign o_id_valid = ~empty;
  assign o_count    = count_q;

endmodule
